regfile_write_scheduler: RTL and testbench

Write-port scheduler and hazard scoreboard for the 16x16 register file. Two writeback sources (ALU and load/store) share the register file's single write port (wr1/wrReg1/wrData1) through per-source FIFOs and round-robin arbitration. A per-register in-flight counter tracks outstanding writes and produces the stall for the read stage when a source operand is still pending.

---
 rtl/regfile_write_scheduler.sv | 164 ++++++++++++++++
 tb/tb_regfile_write_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_scheduler.sv
// Shares the register file write port between the ALU and load/store writeback paths
// and keeps a per-register in-flight count that drives the read-stage operand stall.
module regfile_write_scheduler #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int QDEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_reg,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 ls_valid,
    input  logic [ADDR_W-1:0]    ls_reg,
    input  logic [DATA_W-1:0]    ls_data,
    output logic                 ls_ready,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_reg,
    output logic                 issue_ready,
    input  logic                 chk_en,
    input  logic [ADDR_W-1:0]    chk_reg1,
    input  logic [ADDR_W-1:0]    chk_reg2,
    output logic                 stall,
    output logic                 wr1,
    output logic [ADDR_W-1:0]    wrReg1,
    output logic [DATA_W-1:0]    wrData1,
    output logic [2**ADDR_W-1:0] pending
);

    localparam int NREG = 2**ADDR_W;
    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);

    // Handshake: a source entry transfers at a rising edge where valid && ready;
    // ready depends only on FIFO occupancy, and valid while not ready is ignored.

    // Index 0 is the ALU source, index 1 is the load/store source.
    logic [ADDR_W-1:0] r_q_reg  [2][QDEPTH];
    logic [DATA_W-1:0] r_q_data [2][QDEPTH];
    logic [PW-1:0]     r_wptr   [2];
    logic [PW-1:0]     r_rptr   [2];
    logic [PW:0]       r_occ    [2];

    logic [ADDR_W-1:0] w_in_reg   [2];
    logic [DATA_W-1:0] w_in_data  [2];
    logic [ADDR_W-1:0] w_head_reg [2];
    logic [DATA_W-1:0] w_head_data[2];
    logic [1:0]        w_push;
    logic [1:0]        w_pop;
    logic [1:0]        w_has;
    logic [1:0]        w_ready;
    logic              w_grant_ls;

    logic              r_last_ls;
    logic              r_wr1;
    logic [ADDR_W-1:0] r_wrreg1;
    logic [DATA_W-1:0] r_wrdata1;

    logic [1:0]        r_cnt [NREG];
    logic [NREG-1:0]   w_inc;
    logic [NREG-1:0]   w_dec;
    logic [NREG-1:0]   w_pending;

    assign w_in_reg[0]  = alu_reg;
    assign w_in_reg[1]  = ls_reg;
    assign w_in_data[0] = alu_data;
    assign w_in_data[1] = ls_data;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_has[s]       = (r_occ[s] != '0);
            w_ready[s]     = (r_occ[s] != FULL);
            w_head_reg[s]  = r_q_reg[s][r_rptr[s]];
            w_head_data[s] = r_q_data[s][r_rptr[s]];
        end
    end

    assign alu_ready = w_ready[0];
    assign ls_ready  = w_ready[1];
    assign w_push[0] = alu_valid && w_ready[0];
    assign w_push[1] = ls_valid && w_ready[1];

    // On a tie the source that did not win last time gets the port.
    assign w_grant_ls = w_has[1] && (!w_has[0] || !r_last_ls);
    assign w_pop[0]   = w_has[0] && !w_grant_ls;
    assign w_pop[1]   = w_grant_ls;

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (w_push[s]) begin
                r_q_reg[s][r_wptr[s]]  <= w_in_reg[s];
                r_q_data[s][r_wptr[s]] <= w_in_data[s];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                r_wptr[s] <= '0;
                r_rptr[s] <= '0;
                r_occ[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) r_wptr[s] <= r_wptr[s] + PW'(1);
                if (w_pop[s])  r_rptr[s] <= r_rptr[s] + PW'(1);
                if (w_push[s] && !w_pop[s])      r_occ[s] <= r_occ[s] + (PW+1)'(1);
                else if (!w_push[s] && w_pop[s]) r_occ[s] <= r_occ[s] - (PW+1)'(1);
            end
        end
    end

    // Write port: wrReg1/wrData1 keep their last value while no write is granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr1     <= 1'b0;
            r_wrreg1  <= '0;
            r_wrdata1 <= '0;
            r_last_ls <= 1'b1;
        end else if (w_pop[0] || w_pop[1]) begin
            r_wr1     <= 1'b1;
            r_wrreg1  <= w_grant_ls ? w_head_reg[1]  : w_head_reg[0];
            r_wrdata1 <= w_grant_ls ? w_head_data[1] : w_head_data[0];
            r_last_ls <= w_grant_ls;
        end else begin
            r_wr1     <= 1'b0;
        end
    end

    assign wr1     = r_wr1;
    assign wrReg1  = r_wrreg1;
    assign wrData1 = r_wrdata1;

    assign issue_ready = (r_cnt[issue_reg] != 2'd3);

    // The decrement lands on the same edge the register file commits, so the
    // stall stays up through the cycle where the write is still on the port.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_inc[i]     = issue_valid && issue_ready && (issue_reg == ADDR_W'(i));
            w_dec[i]     = r_wr1 && (r_wrreg1 == ADDR_W'(i));
            w_pending[i] = (r_cnt[i] != 2'd0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= 2'd0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_cnt[i] <= r_cnt[i] + 2'd1;
                else if (w_dec[i] && !w_inc[i] && r_cnt[i] != 2'd0)
                    r_cnt[i] <= r_cnt[i] - 2'd1;
            end
        end
    end

    assign pending = w_pending;
    assign stall   = chk_en && (r_cnt[chk_reg1] != 2'd0 || r_cnt[chk_reg2] != 2'd0);

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the write scheduler.
module tb_regfile_write_scheduler;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int QDEPTH = 2;
    localparam int NREG   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid, ls_valid, issue_valid, chk_en;
    logic [ADDR_W-1:0] alu_reg, ls_reg, issue_reg, chk_reg1, chk_reg2;
    logic [DATA_W-1:0] alu_data, ls_data;
    logic              alu_ready, ls_ready, issue_ready, stall, wr1;
    logic [ADDR_W-1:0] wrReg1;
    logic [DATA_W-1:0] wrData1;
    logic [NREG-1:0]   pending;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_write_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .ls_valid(ls_valid), .ls_reg(ls_reg), .ls_data(ls_data), .ls_ready(ls_ready),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
        .chk_en(chk_en), .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .stall(stall),
        .wr1(wr1), .wrReg1(wrReg1), .wrData1(wrData1), .pending(pending)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              qa[$];
    ent_t              ql[$];
    int                m_cnt[NREG];
    bit                m_last_ls;
    logic              m_wr1;
    logic [ADDR_W-1:0] m_reg;
    logic [DATA_W-1:0] m_data;

    task automatic model_reset();
        qa.delete();
        ql.delete();
        for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        m_last_ls = 1'b1;
        m_wr1     = 1'b0;
        m_reg     = '0;
        m_data    = '0;
    endtask

    task automatic model_edge();
        bit   room_a, room_l, take_ls, inc, dec;
        logic [ADDR_W-1:0] old_reg;
        ent_t e;
        if (reset) begin
            model_reset();
            return;
        end
        room_a  = qa.size() < QDEPTH;
        room_l  = ql.size() < QDEPTH;
        inc     = issue_valid && (m_cnt[issue_reg] != 3);
        dec     = m_wr1;
        old_reg = m_reg;
        if (qa.size() > 0 || ql.size() > 0) begin
            if (qa.size() > 0 && ql.size() > 0) take_ls = !m_last_ls;
            else                                take_ls = (ql.size() > 0);
            if (take_ls) e = ql.pop_front();
            else         e = qa.pop_front();
            m_last_ls = take_ls;
            m_wr1  = 1'b1;
            m_reg  = e.r;
            m_data = e.d;
        end else begin
            m_wr1 = 1'b0;
        end
        if (alu_valid && room_a) qa.push_back('{r: alu_reg, d: alu_data});
        if (ls_valid && room_l)  ql.push_back('{r: ls_reg, d: ls_data});
        if (!(inc && dec && issue_reg == old_reg)) begin
            if (inc) m_cnt[issue_reg]++;
            if (dec && m_cnt[old_reg] > 0) m_cnt[old_reg]--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_idle();
        alu_valid = 0; alu_reg = '0; alu_data = '0;
        ls_valid = 0;  ls_reg = '0;  ls_data = '0;
        issue_valid = 0; issue_reg = '0;
        chk_en = 0; chk_reg1 = '0; chk_reg2 = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        model_reset();
        chk_en = 1; chk_reg1 = 4'd0; chk_reg2 = 4'd15;
        #3;
        n_checks++;
        if ({wr1, wrReg1, wrData1} !== '0) $display("FAIL reset_wr: got %0h/%0h/%0h expected 0/0/0", wr1, wrReg1, wrData1);
        else n_pass++;
        n_checks++;
        if ({alu_ready, ls_ready, issue_ready} !== 3'b111) $display("FAIL reset_ready: got %b expected 111", {alu_ready, ls_ready, issue_ready});
        else n_pass++;
        n_checks++;
        if (pending !== '0 || stall !== 1'b0) $display("FAIL reset_pending: got pending=%0h stall=%b expected 0/0", pending, stall);
        else n_pass++;
        tick();
        reset = 1'b0;
        drive_idle();
        tick();
    endtask

    task automatic test_alu_only();
        do_reset();
        alu_valid = 1; alu_reg = 4'd5; alu_data = 16'h1234;
        tick();
        drive_idle();
        n_checks++;
        if (wr1 !== 1'b0) $display("FAIL alu_only_edge1: got wr1=%b expected 0", wr1);
        else n_pass++;
        tick();
        n_checks++;
        if (wr1 !== 1'b1 || wrReg1 !== 4'd5 || wrData1 !== 16'h1234)
            $display("FAIL alu_only_write: got %b/%0h/%0h expected 1/5/1234", wr1, wrReg1, wrData1);
        else n_pass++;
        tick();
        n_checks++;
        if (wr1 !== 1'b0 || wrReg1 !== 4'd5 || wrData1 !== 16'h1234)
            $display("FAIL alu_only_idle: got %b/%0h/%0h expected 0/5/1234", wr1, wrReg1, wrData1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_seq[4];
        exp_seq[0] = 16'hA001; exp_seq[1] = 16'hB001; exp_seq[2] = 16'hA002; exp_seq[3] = 16'hB002;
        do_reset();
        alu_valid = 1; alu_reg = 4'd1; alu_data = 16'hA001;
        ls_valid  = 1; ls_reg  = 4'd2; ls_data  = 16'hB001;
        tick();
        alu_reg = 4'd3; alu_data = 16'hA002;
        ls_reg  = 4'd4; ls_data  = 16'hB002;
        tick();
        drive_idle();
        n_checks++;
        if (ls_ready !== 1'b0) $display("FAIL b2b_ls_full: got ls_ready=%b expected 0", ls_ready);
        else n_pass++;
        n_checks++;
        if (alu_ready !== (qa.size() < QDEPTH)) $display("FAIL b2b_alu_ready: got %b expected %b", alu_ready, qa.size() < QDEPTH);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (wr1 !== 1'b1 || wrData1 !== exp_seq[k])
                $display("FAIL b2b_seq%0d: got %b/%0h expected 1/%0h", k, wr1, wrData1, exp_seq[k]);
            else n_pass++;
            if (k == 0) begin
                tick();
                n_checks++;
                if (ls_ready !== 1'b1) $display("FAIL b2b_ls_reopen: got ls_ready=%b expected 1", ls_ready);
                else n_pass++;
            end else begin
                tick();
            end
        end
        n_checks++;
        if (wr1 !== 1'b0) $display("FAIL b2b_drained: got wr1=%b expected 0", wr1);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        do_reset();
        issue_valid = 1; issue_reg = 4'd3;
        tick();
        issue_valid = 0;
        chk_en = 1; chk_reg1 = 4'd3; chk_reg2 = 4'd0;
        alu_valid = 1; alu_reg = 4'd3; alu_data = 16'h0333;
        #1;
        n_checks++;
        if (stall !== 1'b1 || pending[3] !== 1'b1) $display("FAIL sb_issued: got stall=%b pend3=%b expected 1/1", stall, pending[3]);
        else n_pass++;
        tick();
        alu_valid = 0;
        tick();
        n_checks++;
        if (wr1 !== 1'b1 || wrReg1 !== 4'd3 || stall !== 1'b1)
            $display("FAIL sb_commit_cycle: got wr1=%b reg=%0h stall=%b expected 1/3/1", wr1, wrReg1, stall);
        else n_pass++;
        tick();
        n_checks++;
        if (stall !== 1'b0 || pending[3] !== 1'b0) $display("FAIL sb_released: got stall=%b pend3=%b expected 0/0", stall, pending[3]);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1; issue_reg = 4'd7;
            tick();
        end
        issue_valid = 0;
        #1;
        n_checks++;
        if (issue_ready !== 1'b0) $display("FAIL sat_full: got issue_ready=%b expected 0", issue_ready);
        else n_pass++;
        issue_reg = 4'd6;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1) $display("FAIL sat_other_reg: got issue_ready=%b expected 1", issue_ready);
        else n_pass++;
        issue_valid = 1; issue_reg = 4'd7;
        tick();
        issue_valid = 0;
        alu_valid = 1; alu_reg = 4'd7; alu_data = 16'h7777;
        tick();
        alu_valid = 0;
        tick();
        n_checks++;
        if (wr1 !== 1'b1 || issue_ready !== 1'b0) $display("FAIL sat_write_on_port: got wr1=%b issue_ready=%b expected 1/0", wr1, issue_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (issue_ready !== 1'b1) $display("FAIL sat_after_commit: got issue_ready=%b expected 1", issue_ready);
        else n_pass++;
        alu_valid = 1; alu_data = 16'h7778;
        tick();
        alu_valid = 0;
        tick();
        issue_valid = 1;
        tick();
        issue_valid = 0;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1 || pending[7] !== 1'b1) $display("FAIL sat_same_edge: got issue_ready=%b pend7=%b expected 1/1", issue_ready, pending[7]);
        else n_pass++;
        issue_valid = 1;
        tick();
        issue_valid = 0;
        #1;
        n_checks++;
        if (issue_ready !== 1'b0) $display("FAIL sat_refill: got issue_ready=%b expected 0", issue_ready);
        else n_pass++;
    endtask

    task automatic test_untracked();
        do_reset();
        chk_en = 1; chk_reg1 = 4'd9; chk_reg2 = 4'd9;
        ls_valid = 1; ls_reg = 4'd9; ls_data = 16'h0999;
        tick();
        ls_valid = 0;
        tick();
        n_checks++;
        if (wr1 !== 1'b1 || wrReg1 !== 4'd9 || stall !== 1'b0)
            $display("FAIL untracked_write: got wr1=%b reg=%0h stall=%b expected 1/9/0", wr1, wrReg1, stall);
        else n_pass++;
        tick();
        n_checks++;
        if (stall !== 1'b0 || pending[9] !== 1'b0) $display("FAIL untracked_after: got stall=%b pend9=%b expected 0/0", stall, pending[9]);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        issue_valid = 1; issue_reg = 4'd2;
        alu_valid = 1; alu_reg = 4'd1; alu_data = 16'hC001;
        ls_valid  = 1; ls_reg  = 4'd2; ls_data  = 16'hD001;
        tick();
        issue_valid = 0;
        alu_data = 16'hC002; ls_data = 16'hD002;
        tick();
        drive_idle();
        n_checks++;
        if (wr1 !== 1'b1 || pending === '0) $display("FAIL areset_setup: got wr1=%b pending=%0h expected 1/nonzero", wr1, pending);
        else n_pass++;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (wr1 !== 1'b0 || alu_ready !== 1'b1 || ls_ready !== 1'b1 || pending !== '0)
            $display("FAIL areset_immediate: got wr1=%b rdy=%b%b pending=%0h expected 0/11/0", wr1, alu_ready, ls_ready, pending);
        else n_pass++;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (wr1 !== 1'b0) $display("FAIL areset_no_drain%0d: got wr1=%b expected 0", k, wr1);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [NREG-1:0] ep;
        bit exp_stall;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            alu_valid   = ($urandom_range(0, 99) < 45);
            alu_reg     = ADDR_W'($urandom_range(0, 3));
            alu_data    = DATA_W'($urandom);
            ls_valid    = ($urandom_range(0, 99) < 45);
            ls_reg      = ADDR_W'($urandom_range(0, 3));
            ls_data     = DATA_W'($urandom);
            issue_valid = ($urandom_range(0, 99) < 50);
            issue_reg   = ADDR_W'($urandom_range(0, 3));
            chk_en      = $urandom_range(0, 1);
            chk_reg1    = ADDR_W'($urandom_range(0, 5));
            chk_reg2    = ADDR_W'($urandom_range(0, 5));
            #1;
            for (int i = 0; i < NREG; i++) ep[i] = (m_cnt[i] != 0);
            exp_stall = chk_en && (m_cnt[chk_reg1] != 0 || m_cnt[chk_reg2] != 0);
            n_checks++;
            if (alu_ready !== (qa.size() < QDEPTH) || ls_ready !== (ql.size() < QDEPTH))
                $display("FAIL rnd_ready c%0d: got %b%b expected %b%b", c, alu_ready, ls_ready, qa.size() < QDEPTH, ql.size() < QDEPTH);
            else n_pass++;
            n_checks++;
            if (issue_ready !== (m_cnt[issue_reg] != 3) || stall !== exp_stall || pending !== ep)
                $display("FAIL rnd_score c%0d: got ir=%b st=%b pend=%0h expected %b/%b/%0h", c, issue_ready, stall, pending, m_cnt[issue_reg] != 3, exp_stall, ep);
            else n_pass++;
            tick();
            n_checks++;
            if (wr1 !== m_wr1 || wrReg1 !== m_reg || wrData1 !== m_data)
                $display("FAIL rnd_port c%0d: got %b/%0h/%0h expected %b/%0h/%0h", c, wr1, wrReg1, wrData1, m_wr1, m_reg, m_data);
            else n_pass++;
        end
        drive_idle();
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        model_reset();
        @(negedge clk);
        test_reset();
        test_alu_only();
        test_back_to_back();
        test_scoreboard();
        test_saturation();
        test_untracked();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
